// File: rtl/prefetch_instruction_cache.sv
// Direct-mapped single-word-line instruction cache with next-line prefetch.
// Memory words arrive byte-reversed and are reordered before storage and delivery.
module prefetch_instruction_cache #(
   parameter int ADDR_WIDTH         = 17,
   parameter int DATA_LEN           = 32,
   parameter int BYTE_SIZE          = 8,
   parameter int I_CACHE_INDEX_SIZE = 3,
   parameter int I_CACHE_SIZE       = 8,
   parameter int PREFETCH_EN        = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic                  inst_fetch_enabled,
   input  logic                  invalidate,
   output logic [DATA_LEN-1:0]   instruction,
   output logic [1:0]            inst_fetch_status,
   input  logic [DATA_LEN-1:0]   mem_data,
   input  logic [1:0]            mem_status,
   output logic [ADDR_WIDTH-1:0] mem_vis_addr,
   output logic [1:0]            mem_vis_signal
);
   // state    | meaning
   // S_IDLE   | waiting for a fetch (or replaying one latched during a prefetch)
   // S_MISS   | demand read outstanding, requester stalled
   // S_PREFETCH | next-line read outstanding, new requests latched as pending

   localparam logic [1:0] I_CACHE_RESTING   = 2'd0;
   localparam logic [1:0] I_CACHE_WORKING   = 2'd1;
   localparam logic [1:0] I_CACHE_STALL     = 2'd2;
   localparam logic [1:0] IF_FINISHED       = 2'd3;
   localparam logic [1:0] MEM_NOP           = 2'd0;
   localparam logic [1:0] MEM_READ          = 2'd1;
   localparam logic [1:0] MEM_INST_FINISHED = 2'd2;

   localparam int TAG_W   = ADDR_WIDTH - I_CACHE_INDEX_SIZE - 2;
   localparam int N_BYTES = DATA_LEN / BYTE_SIZE;

   typedef enum logic [1:0] {S_IDLE, S_MISS, S_PREFETCH} state_t;

   state_t state_q, state_d;

   logic [I_CACHE_SIZE-1:0] valid_q;
   logic [TAG_W-1:0]        tag_q  [I_CACHE_SIZE];
   logic [DATA_LEN-1:0]     data_q [I_CACHE_SIZE];

   logic [ADDR_WIDTH-1:0] req_addr_q, pf_addr_q, pend_addr_q;
   logic                  pend_valid_q, pf_stale_q;

   logic [ADDR_WIDTH-1:0]         lookup_word, deliv_addr, nxt_addr, fill_addr;
   logic [I_CACHE_INDEX_SIZE-1:0] lk_idx, nx_idx, fill_idx;
   logic [TAG_W-1:0]              lk_tag, nx_tag, fill_tag;
   logic                          lookup_req, lookup_hit, nxt_present, go_pf;
   logic                          mem_done, pf_match;
   logic [DATA_LEN-1:0]           mem_word;

   logic [1:0]            status_d, sig_d;
   logic [ADDR_WIDTH-1:0] vaddr_d;
   logic [DATA_LEN-1:0]   inst_d;
   logic                  inst_load, fill_en, miss_load, pf_load, pend_set, pend_clr;

   // A request latched during a prefetch takes priority over the live port.
   assign lookup_req  = pend_valid_q | inst_fetch_enabled;
   assign lookup_word = (pend_valid_q ? pend_addr_q : inst_addr) & ~ADDR_WIDTH'(3);
   assign lk_idx      = lookup_word[I_CACHE_INDEX_SIZE+1:2];
   assign lk_tag      = lookup_word[ADDR_WIDTH-1:I_CACHE_INDEX_SIZE+2];
   assign lookup_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !invalidate;

   assign deliv_addr  = (state_q == S_MISS) ? req_addr_q : lookup_word;
   assign nxt_addr    = deliv_addr + ADDR_WIDTH'(4);
   assign nx_idx      = nxt_addr[I_CACHE_INDEX_SIZE+1:2];
   assign nx_tag      = nxt_addr[ADDR_WIDTH-1:I_CACHE_INDEX_SIZE+2];
   assign nxt_present = valid_q[nx_idx] && (tag_q[nx_idx] == nx_tag) && !invalidate;
   assign go_pf       = (PREFETCH_EN != 0) && !nxt_present;

   assign mem_done    = (mem_status == MEM_INST_FINISHED);
   assign pf_match    = lookup_req && (lookup_word == pf_addr_q);
   assign fill_idx    = fill_addr[I_CACHE_INDEX_SIZE+1:2];
   assign fill_tag    = fill_addr[ADDR_WIDTH-1:I_CACHE_INDEX_SIZE+2];

   always_comb begin
      mem_word = '0;
      for (int i = 0; i < N_BYTES; i++)
         mem_word[i*BYTE_SIZE +: BYTE_SIZE] = mem_data[(N_BYTES-1-i)*BYTE_SIZE +: BYTE_SIZE];
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (lookup_req) begin
               if (!lookup_hit)  state_d = S_MISS;
               else if (go_pf)   state_d = S_PREFETCH;
            end
         end
         S_MISS:     if (mem_done) state_d = go_pf ? S_PREFETCH : S_IDLE;
         S_PREFETCH: if (mem_done) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      status_d  = I_CACHE_RESTING;
      sig_d     = MEM_NOP;
      vaddr_d   = mem_vis_addr;
      inst_d    = mem_word;
      inst_load = 1'b0;
      fill_en   = 1'b0;
      fill_addr = req_addr_q;
      miss_load = 1'b0;
      pf_load   = 1'b0;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (lookup_req) begin
               pend_clr = 1'b1;
               if (lookup_hit) begin
                  inst_load = 1'b1;
                  inst_d    = data_q[lk_idx];
                  status_d  = IF_FINISHED;
                  if (go_pf) begin
                     sig_d   = MEM_READ;
                     vaddr_d = nxt_addr;
                     pf_load = 1'b1;
                  end
               end else begin
                  miss_load = 1'b1;
                  sig_d     = MEM_READ;
                  vaddr_d   = lookup_word;
                  status_d  = I_CACHE_STALL;
               end
            end
         end
         S_MISS: begin
            if (mem_done) begin
               fill_en   = 1'b1;
               inst_load = 1'b1;
               status_d  = IF_FINISHED;
               if (go_pf) begin
                  sig_d   = MEM_READ;
                  vaddr_d = nxt_addr;
                  pf_load = 1'b1;
               end
            end else begin
               sig_d    = MEM_READ;
               status_d = I_CACHE_STALL;
            end
         end
         S_PREFETCH: begin
            fill_addr = pf_addr_q;
            if (mem_done) begin
               // A prefetch that overlapped an invalidate is delivered but not kept.
               fill_en = !(pf_stale_q || invalidate);
               if (pf_match) begin
                  inst_load = 1'b1;
                  status_d  = IF_FINISHED;
                  pend_clr  = 1'b1;
               end else if (inst_fetch_enabled && !pend_valid_q) begin
                  pend_set = 1'b1;
               end
            end else begin
               sig_d    = MEM_READ;
               status_d = I_CACHE_WORKING;
               pend_set = inst_fetch_enabled && !pend_valid_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q           <= '0;
         instruction       <= '0;
         inst_fetch_status <= I_CACHE_RESTING;
         mem_vis_signal    <= MEM_NOP;
         mem_vis_addr      <= '0;
         req_addr_q        <= '0;
         pf_addr_q         <= '0;
         pend_addr_q       <= '0;
         pend_valid_q      <= 1'b0;
         pf_stale_q        <= 1'b0;
      end else begin
         if (invalidate) valid_q <= '0;
         if (fill_en)    valid_q[fill_idx] <= 1'b1;
         inst_fetch_status <= status_d;
         mem_vis_signal    <= sig_d;
         mem_vis_addr      <= vaddr_d;
         if (inst_load) instruction <= inst_d;
         if (miss_load) req_addr_q <= lookup_word;
         if (pf_load) begin
            pf_addr_q  <= nxt_addr;
            pf_stale_q <= invalidate;
         end else if (state_q == S_PREFETCH && invalidate) begin
            pf_stale_q <= 1'b1;
         end
         if (pend_clr) begin
            pend_valid_q <= 1'b0;
         end else if (pend_set) begin
            pend_valid_q <= 1'b1;
            pend_addr_q  <= lookup_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && fill_en) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= mem_word;
      end
   end
endmodule

// File: tb/tb_prefetch_instruction_cache.sv
// Scoreboard bench for prefetch_instruction_cache: stimulus queues expected
// deliveries and memory reads; a monitor and a memory model check them.
module tb_prefetch_instruction_cache;
   localparam int AW = 17;
   localparam logic [1:0] RESTING = 2'd0, WORKING = 2'd1, STALL = 2'd2, FINISHED = 2'd3;
   localparam logic [1:0] NOP = 2'd0, READ = 2'd1, FIN = 2'd2, MS_IDLE = 2'd0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] inst_addr = '0;
   logic          inst_fetch_enabled = 1'b0;
   logic          invalidate = 1'b0;
   logic [31:0]   instruction;
   logic [1:0]    inst_fetch_status;
   logic [31:0]   mem_data = '0;
   logic [1:0]    mem_status = MS_IDLE;
   logic [AW-1:0] mem_vis_addr;
   logic [1:0]    mem_vis_signal;

   always #5 clk = ~clk;

   prefetch_instruction_cache dut (
      .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_fetch_enabled(inst_fetch_enabled),
      .invalidate(invalidate), .instruction(instruction), .inst_fetch_status(inst_fetch_status),
      .mem_data(mem_data), .mem_status(mem_status), .mem_vis_addr(mem_vis_addr),
      .mem_vis_signal(mem_vis_signal)
   );

   int checks = 0, passed = 0;
   logic [31:0]   exp_inst_q[$];
   logic [AW-1:0] exp_rd_q[$];
   logic          mem_freeze = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%h required=%h", nm, got, exp);
   endtask

   task automatic timeout(input string nm);
      checks++;
      $display("FAIL %s timed out", nm);
   endtask

   function automatic logic [31:0] word_at(input logic [AW-1:0] a);
      case (a)
         17'h00000: word_at = 32'h00000013;
         17'h00004: word_at = 32'h00100093;
         17'h00008: word_at = 32'h00200113;
         17'h0000C: word_at = 32'h00300193;
         17'h00020: word_at = 32'h00a00513;
         17'h00040: word_at = 32'h0ff00793;
         17'h1FFFC: word_at = 32'h0000006f;
         default:   word_at = 32'hdead0000 | 32'(a);
      endcase
   endfunction

   function automatic logic [31:0] swap(input logic [31:0] w);
      swap = {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // delivery monitor
   initial forever begin
      @(negedge clk);
      if (!rst && inst_fetch_status == FINISHED) begin
         if (exp_inst_q.size() == 0) begin
            checks++;
            $display("FAIL delivery unexpected got=%h required=none", instruction);
         end else begin
            chk("delivery", instruction, exp_inst_q.pop_front());
         end
      end
   end

   // memory model: accepts one read, answers after a fixed latency
   bit            resp_pending = 1'b0;
   int            cnt = 0;
   logic [AW-1:0] resp_addr = '0;
   initial forever begin
      @(negedge clk);
      mem_status = MS_IDLE;
      if (resp_pending) begin
         if (!mem_freeze) begin
            if (cnt == 0) begin
               mem_status   = FIN;
               mem_data     = swap(word_at(resp_addr));
               resp_pending = 1'b0;
            end else begin
               cnt--;
            end
         end
      end else if (!rst && mem_vis_signal == READ) begin
         if (exp_rd_q.size() == 0) begin
            checks++;
            $display("FAIL mem_read unexpected got=%h required=none", mem_vis_addr);
         end else begin
            chk("mem_read_addr", 32'(mem_vis_addr), 32'(exp_rd_q.pop_front()));
         end
         resp_addr    = mem_vis_addr;
         cnt          = 2;
         resp_pending = 1'b1;
      end
   end

   // called at a negedge; leaves enable high across one rising edge
   task automatic fetch(input logic [AW-1:0] a);
      inst_addr          = a;
      inst_fetch_enabled = 1'b1;
      @(negedge clk);
      inst_fetch_enabled = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (inst_fetch_status == FINISHED) return;
      end
      timeout(nm);
   endtask

   task automatic wait_mem_fin(input string nm);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (mem_status == FIN) begin
            @(negedge clk);
            return;
         end
      end
      timeout(nm);
      @(negedge clk);
   endtask

   task automatic wait_quiet(input string nm);
      int q = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (mem_vis_signal == NOP) q++;
         else q = 0;
         if (q >= 3) return;
      end
      timeout(nm);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_instruction", instruction, 32'h0);
      chk("reset_status", 32'(inst_fetch_status), 32'(RESTING));
      chk("reset_mem_signal", 32'(mem_vis_signal), 32'(NOP));
      chk("reset_mem_addr", 32'(mem_vis_addr), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // cold miss on 0x0, then prefetch of 0x4
      exp_rd_q.push_back(17'h00000); exp_rd_q.push_back(17'h00004);
      exp_inst_q.push_back(32'h00000013);
      fetch(17'h00000);
      chk("miss_stall", 32'(inst_fetch_status), 32'(STALL));
      wait_mem_fin("miss0_fin");
      chk("miss0_finished", 32'(inst_fetch_status), 32'(FINISHED));
      chk("miss0_pf_signal", 32'(mem_vis_signal), 32'(READ));
      chk("miss0_pf_addr", 32'(mem_vis_addr), 32'h4);
      wait_quiet("quiet1");

      // hit on the prefetched word, one cycle latency, prefetch of 0x8
      exp_rd_q.push_back(17'h00008);
      exp_inst_q.push_back(32'h00100093);
      fetch(17'h00004);
      chk("hit4_finished", 32'(inst_fetch_status), 32'(FINISHED));
      chk("hit4_pf_addr", 32'(mem_vis_addr), 32'h8);
      wait_quiet("quiet2");

      // conflict: 0x20 evicts 0x0, then 0x0 refetches
      exp_rd_q.push_back(17'h00020); exp_rd_q.push_back(17'h00024);
      exp_inst_q.push_back(32'h00a00513);
      fetch(17'h00020);
      wait_done("conflict20");
      wait_quiet("quiet3");
      exp_rd_q.push_back(17'h00000); exp_rd_q.push_back(17'h00004);
      exp_inst_q.push_back(32'h00000013);
      fetch(17'h00000);
      wait_done("refetch0");

      // request 0x4 while its prefetch is outstanding
      exp_inst_q.push_back(32'h00100093);
      fetch(17'h00004);
      chk("pend_working", 32'(inst_fetch_status), 32'(WORKING));
      wait_mem_fin("pend4_fin");
      chk("pend4_finished", 32'(inst_fetch_status), 32'(FINISHED));
      chk("pend4_mem_nop", 32'(mem_vis_signal), 32'(NOP));
      wait_quiet("quiet4");

      // request 0x40 during prefetch of 0xC: replayed as a miss afterwards
      exp_rd_q.push_back(17'h0000C);
      exp_inst_q.push_back(32'h00200113);
      fetch(17'h00008);
      chk("hit8_finished", 32'(inst_fetch_status), 32'(FINISHED));
      exp_rd_q.push_back(17'h00040); exp_rd_q.push_back(17'h00044);
      exp_inst_q.push_back(32'h0ff00793);
      fetch(17'h00040);
      chk("pend40_working", 32'(inst_fetch_status), 32'(WORKING));
      wait_mem_fin("pf_c_fin");
      chk("pend40_resting", 32'(inst_fetch_status), 32'(RESTING));
      @(negedge clk);
      chk("pend40_replay_stall", 32'(inst_fetch_status), 32'(STALL));
      wait_done("miss40");
      wait_quiet("quiet5");

      // warm 0x0/0x4, invalidate, then 0x0 misses again
      exp_rd_q.push_back(17'h00000); exp_rd_q.push_back(17'h00004);
      exp_inst_q.push_back(32'h00000013);
      fetch(17'h00000);
      wait_done("warm0");
      wait_quiet("quiet6");
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      exp_rd_q.push_back(17'h00000); exp_rd_q.push_back(17'h00004);
      exp_inst_q.push_back(32'h00000013);
      fetch(17'h00000);
      wait_done("inval_miss0");
      wait_quiet("quiet7");

      // invalidate during the prefetch of 0xC: 0xC must not be cached
      exp_rd_q.push_back(17'h00008); exp_rd_q.push_back(17'h0000C);
      exp_inst_q.push_back(32'h00200113);
      fetch(17'h00008);
      wait_done("miss8");
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      wait_quiet("quiet8");
      exp_rd_q.push_back(17'h0000C); exp_rd_q.push_back(17'h00010);
      exp_inst_q.push_back(32'h00300193);
      fetch(17'h0000C);
      chk("stale_c_miss", 32'(inst_fetch_status), 32'(STALL));
      wait_done("missc");
      wait_quiet("quiet9");

      // top of address space: prefetch wraps to 0x0
      exp_rd_q.push_back(17'h1FFFC); exp_rd_q.push_back(17'h00000);
      exp_inst_q.push_back(32'h0000006f);
      fetch(17'h1FFFC);
      wait_done("miss_top");
      chk("wrap_pf_addr", 32'(mem_vis_addr), 32'h0);
      chk("wrap_pf_signal", 32'(mem_vis_signal), 32'(READ));
      wait_quiet("quiet10");

      // reset in the middle of a miss; the late response must be ignored
      mem_freeze = 1'b1;
      exp_rd_q.push_back(17'h00020);
      fetch(17'h00020);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mem_freeze = 1'b0;
      wait_mem_fin("late_fin");
      chk("late_instruction", instruction, 32'h0);
      chk("late_status", 32'(inst_fetch_status), 32'(RESTING));
      chk("late_mem_signal", 32'(mem_vis_signal), 32'(NOP));
      chk("late_mem_addr", 32'(mem_vis_addr), 32'h0);
      exp_rd_q.push_back(17'h00000); exp_rd_q.push_back(17'h00004);
      exp_inst_q.push_back(32'h00000013);
      fetch(17'h00000);
      wait_done("post_reset_miss0");
      wait_quiet("quiet11");

      chk("inst_queue_drained", 32'(exp_inst_q.size()), 32'h0);
      chk("read_queue_drained", 32'(exp_rd_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/prefetch_instruction_cache.md
# prefetch_instruction_cache

Parametrised, direct-mapped instruction cache with next-line prefetch, placed between the instruction-fetch stage and the main-memory controller. It serves 32-bit instruction fetches from a configurable number of single-word lines. On a miss it reads from memory and reorders the byte-reversed memory word. After every delivered fetch it can prefetch the next sequential word, and it supports whole-cache invalidation for `fence.i`.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: byte-address width.
- `DATA_LEN`, 32: instruction and memory word width.
- `BYTE_SIZE`, 8: byte width used for reordering.
- `I_CACHE_INDEX_SIZE`, 3: log2 of the line count.
- `I_CACHE_SIZE`, 8: line count; must equal 2**`I_CACHE_INDEX_SIZE`.
- `PREFETCH_EN`, 1: enables next-line prefetch (0 = demand-only).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `inst_addr`  in  ADDR_WIDTH  fetch byte address; bits [1:0] are ignored.
- `inst_fetch_enabled`  in  1  fetch request; sampled only in IDLE.
- `invalidate`  in  1  clears all valid bits.
- `instruction`  out  DATA_LEN  fetched instruction, held until the next delivery.
- `inst_fetch_status`  out  2  one of `I_CACHE_RESTING`, `I_CACHE_WORKING`, `I_CACHE_STALL`, `IF_FINISHED`.
- `mem_data`  in  DATA_LEN  memory word, byte-reversed.
- `mem_status`  in  2  `MEM_INST_FINISHED` marks the cycle `mem_data` is valid.
- `mem_vis_addr`  out  ADDR_WIDTH  memory read address, word-aligned.
- `mem_vis_signal`  out  2  `MEM_NOP` or `MEM_READ`.

## Operation
- Address split:
  - index = addr[I_CACHE_INDEX_SIZE+1:2]
  - tag = addr[ADDR_WIDTH-1:I_CACHE_INDEX_SIZE+2]
  - each line holds valid, tag and data.
- Reorder: the line/instruction word is {mem_data[7:0], mem_data[15:8], mem_data[23:16], mem_data[31:24]}.
- Reset values:
  - all valid bits = 0
  - `instruction` = 0
  - `inst_fetch_status` = `I_CACHE_RESTING`
  - `mem_vis_signal` = `MEM_NOP`
  - `mem_vis_addr` = 0
  - state = IDLE
- Reset dominates every other input, including mid-miss; an in-flight memory response arriving after reset is ignored.
- **IDLE**
  - `mem_vis_signal` = `MEM_NOP`.
  - If `inst_fetch_enabled` and hit: `instruction` ← line data, status `IF_FINISHED`. Then go to PREFETCH if `PREFETCH_EN` and the next line is not already present; otherwise stay in IDLE.
  - If `inst_fetch_enabled` and miss: latch the word-aligned address, `mem_vis_addr` ← it, `MEM_READ`, status `I_CACHE_STALL`, go to MISS.
  - With no request, status is `I_CACHE_RESTING`.
- **MISS**
  - Hold `MEM_READ` until `mem_status == MEM_INST_FINISHED`.
  - Then write the line (valid=1, tag, data), `instruction` ← reordered word, status `IF_FINISHED`.
  - Then go to PREFETCH with the same conditions as a hit.
- **PREFETCH**
  - Prefetch address = delivered address + 4, modulo 2**ADDR_WIDTH.
  - Entry edge: `mem_vis_addr` ← prefetch address, `MEM_READ`.
  - While waiting, status = `I_CACHE_WORKING`; a concurrent `inst_fetch_enabled` is latched as a pending request.
  - On `MEM_INST_FINISHED`: fill the line, `MEM_NOP`.
    - Pending address equals prefetch address: deliver the new word as `IF_FINISHED` on the same edge.
    - Other pending address: return to IDLE and re-evaluate it next cycle.
    - No pending request: go to IDLE.
- At most one outstanding memory read; a prefetch never chains into a second prefetch.
- Hit test is combinational on `inst_addr` against the array state of that cycle.
- **invalidate**
  - Clears all valid bits on the edge it is sampled. If the same edge also writes a demand (MISS) fill, that line becomes valid; a fill always overrides invalidate.
  - A PREFETCH completion at or after an invalidate in the same prefetch is not written (stale) but is still delivered if it matches the pending address.
  - A hit lookup in the same cycle as `invalidate` is treated as a miss.

## Timing
- Hit: enable sampled at edge N → `IF_FINISHED` and `instruction` valid after edge N+1, for exactly one cycle.
- Miss: `MEM_READ` from edge N+1. Memory finishing in cycle M → `IF_FINISHED` after edge M+1. The prefetch `MEM_READ` to addr+4 starts on that same edge.
- `IF_FINISHED` is a one-cycle pulse. A requester holding enable high issues the next request from the following cycle.
- Conflict: a fill overwrites the indexed line unconditionally (no replacement choice).

## Test plan
- Reset, then fetch 0x00000 with memory returning 0x13000000 → `MEM_READ` at 0x00000, `instruction` = 0x00000013, `IF_FINISHED` one cycle after `MEM_INST_FINISHED`, then prefetch `MEM_READ` at 0x00004.
- After that prefetch completes, fetch 0x00004 → `IF_FINISHED` one cycle after enable, no memory read of 0x00004.
- Fetch 0x00020 (same index as 0x00000 with 8 lines), then 0x00000 → both miss; the second refetches from memory.
- Request 0x00004 while its prefetch is outstanding → `I_CACHE_WORKING` until the memory finishes, then `IF_FINISHED` with that word on the same edge. Request 0x00040 instead → delivered via a fresh miss afterwards.
- Assert `invalidate` for one cycle after warming 0x00000/0x00004, then fetch 0x00000 → miss. Assert `invalidate` mid-prefetch → the prefetched line is not valid afterwards.
- Fetch 0x1FFFC with `ADDR_WIDTH`=17 → prefetch address wraps to 0x00000. Assert `rst` mid-miss → all outputs return to reset values and the late `MEM_INST_FINISHED` is ignored.
